// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480@60 timing constants and pixel types
package vga_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FRONT  = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BACK   = 48;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FRONT  = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BACK   = 33;
    localparam int unsigned PIPE_LAT = 0;

    localparam int unsigned H_TOT       = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOT       = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_ACT_START = H_SYNC + H_BACK;
    localparam int unsigned V_ACT_START = V_SYNC + V_BACK;

    localparam int unsigned COORD_W = 11;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/vga_sync_delay.sv
// rtl/vga_sync_delay.sv - fixed-depth shift register for sync/blank, per-bit reset value
module vga_sync_delay #(
    parameter int unsigned      DEPTH   = 1,
    parameter int unsigned      WIDTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic             qual_early_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

    // LSB is the qualifier; exposing it one stage early lets a companion
    // register land on the same edge as q_o.
    generate
        if (DEPTH == 1) begin : g_tap_input
            assign qual_early_o = d_i[0];
        end else begin : g_tap_stage
            assign qual_early_o = stage_q[DEPTH-2][0];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - VGA raster counters, coordinate issue and aligned DAC output register
module vga_timing_ctrl #(
    parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int unsigned H_FRONT  = vga_pkg::H_FRONT,
    parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
    parameter int unsigned H_BACK   = vga_pkg::H_BACK,
    parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int unsigned V_FRONT  = vga_pkg::V_FRONT,
    parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
    parameter int unsigned V_BACK   = vga_pkg::V_BACK,
    parameter int unsigned PIPE_LAT = vga_pkg::PIPE_LAT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [10:0] o_VGA_X,
    output logic [10:0] o_VGA_Y,
    output logic        o_active,
    input  logic [7:0]  i_R,
    input  logic [7:0]  i_G,
    input  logic [7:0]  i_B,
    output logic [7:0]  o_VGA_R,
    output logic [7:0]  o_VGA_G,
    output logic [7:0]  o_VGA_B,
    output logic        o_VGA_HS,
    output logic        o_VGA_VS,
    output logic        o_VGA_BLANK_N,
    output logic        o_VGA_SYNC_N,
    output logic        o_frame_start
);

    import vga_pkg::*;

    localparam coord_t H_LAST     = coord_t'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam coord_t V_LAST     = coord_t'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam coord_t H_SYNC_END = coord_t'(H_SYNC);
    localparam coord_t V_SYNC_END = coord_t'(V_SYNC);
    localparam coord_t H_ACT_BEG  = coord_t'(H_SYNC + H_BACK);
    localparam coord_t V_ACT_BEG  = coord_t'(V_SYNC + V_BACK);
    localparam coord_t H_ACT_END  = coord_t'(H_SYNC + H_BACK + H_ACTIVE);
    localparam coord_t V_ACT_END  = coord_t'(V_SYNC + V_BACK + V_ACTIVE);
    localparam coord_t ONE        = coord_t'(1);

    coord_t h_cnt_q, h_cnt_d;
    coord_t v_cnt_q, v_cnt_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    always_comb begin
        h_cnt_d = h_cnt_q + ONE;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + ONE;
        end
    end

    logic h_act, v_act, active;

    always_comb begin
        h_act  = (h_cnt_q >= H_ACT_BEG) && (h_cnt_q < H_ACT_END);
        v_act  = (v_cnt_q >= V_ACT_BEG) && (v_cnt_q < V_ACT_END);
        active = h_act && v_act;
    end

    assign o_active = active;
    assign o_VGA_X  = active ? (h_cnt_q - H_ACT_BEG) : '0;
    assign o_VGA_Y  = active ? (v_cnt_q - V_ACT_BEG) : '0;

    // Gated by reset so the strobe stays low while the counters are held at (0,0).
    assign o_frame_start = !i_rst && (h_cnt_q == '0) && (v_cnt_q == '0);

    logic [2:0] sync_raw, sync_dly;
    logic       blank_early;

    assign sync_raw = {h_cnt_q >= H_SYNC_END, v_cnt_q >= V_SYNC_END, active};

    vga_sync_delay #(
        .DEPTH   (PIPE_LAT + 1),
        .WIDTH   (3),
        .RST_VAL (3'b110)
    ) u_sync_delay (
        .clk_i        (i_clk),
        .rst_i        (i_rst),
        .d_i          (sync_raw),
        .q_o          (sync_dly),
        .qual_early_o (blank_early)
    );

    rgb_t rgb_q, rgb_d;

    always_comb begin
        rgb_d = '0;
        if (blank_early) begin
            rgb_d = '{r: i_R, g: i_G, b: i_B};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign o_VGA_R       = rgb_q.r;
    assign o_VGA_G       = rgb_q.g;
    assign o_VGA_B       = rgb_q.b;
    assign o_VGA_HS      = sync_dly[2];
    assign o_VGA_VS      = sync_dly[1];
    assign o_VGA_BLANK_N = sync_dly[0];
    assign o_VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb/tb_vga_timing_ctrl.sv - directed vector bench for vga_timing_ctrl
module tb_vga_timing_ctrl;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #20 clk = ~clk;

    logic [10:0] x0, y0;
    logic        act0, hs0, vs0, bn0, sn0, fs0;
    logic [7:0]  r0, g0, b0;

    vga_timing_ctrl #(.PIPE_LAT(0)) dut0 (
        .i_clk(clk), .i_rst(rst_a),
        .o_VGA_X(x0), .o_VGA_Y(y0), .o_active(act0),
        .i_R(x0[7:0]), .i_G(8'h80), .i_B(8'h01),
        .o_VGA_R(r0), .o_VGA_G(g0), .o_VGA_B(b0),
        .o_VGA_HS(hs0), .o_VGA_VS(vs0), .o_VGA_BLANK_N(bn0),
        .o_VGA_SYNC_N(sn0), .o_frame_start(fs0)
    );

    logic [10:0] x3, y3;
    logic        act3, hs3, vs3, bn3, sn3, fs3;
    logic [7:0]  r3, g3, b3;
    logic [7:0]  dly0, dly1, dly2;

    always @(posedge clk) begin
        dly0 <= x3[7:0];
        dly1 <= dly0;
        dly2 <= dly1;
    end

    vga_timing_ctrl #(.PIPE_LAT(3)) dut3 (
        .i_clk(clk), .i_rst(rst_a),
        .o_VGA_X(x3), .o_VGA_Y(y3), .o_active(act3),
        .i_R(dly2), .i_G(8'h80), .i_B(8'h01),
        .o_VGA_R(r3), .o_VGA_G(g3), .o_VGA_B(b3),
        .o_VGA_HS(hs3), .o_VGA_VS(vs3), .o_VGA_BLANK_N(bn3),
        .o_VGA_SYNC_N(sn3), .o_frame_start(fs3)
    );

    logic [10:0] xs, ys;
    logic        acts, hss, vss, bns, sns, fss;
    logic [7:0]  rs, gs, bs;

    vga_timing_ctrl #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .PIPE_LAT(0)
    ) dut_s (
        .i_clk(clk), .i_rst(rst_b),
        .o_VGA_X(xs), .o_VGA_Y(ys), .o_active(acts),
        .i_R(8'hFF), .i_G(8'h80), .i_B(8'h01),
        .o_VGA_R(rs), .o_VGA_G(gs), .o_VGA_B(bs),
        .o_VGA_HS(hss), .o_VGA_VS(vss), .o_VGA_BLANK_N(bns),
        .o_VGA_SYNC_N(sns), .o_frame_start(fss)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int k;
        int x;
        int y;
        int act;
        int fs;
        int hs;
        int vs;
        int bn;
        int r;
        int bn3;
        int r3;
    } vec_t;

    vec_t tbl[$];
    int   kc;
    int   hs_low, vs_low, bn_high, fs_cnt, rgb_bad;

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;

        // k = rising edges since reset release; pixel output at k reflects counters of k-1-PIPE_LAT
        //            k      x    y act fs hs vs bn  r     bn3 r3
        tbl.push_back('{0,     0,   0, 0, 1, 1, 1, 0, 0,     0, 0});
        tbl.push_back('{1,     0,   0, 0, 0, 0, 0, 0, 0,    -1, -1});
        tbl.push_back('{96,    0,   0, 0, 0, 0, 0, 0, 0,    -1, -1});
        tbl.push_back('{97,    0,   0, 0, 0, 1, 0, 0, 0,    -1, -1});
        tbl.push_back('{800,   0,   0, 0, 0, 1, 0, 0, 0,    -1, -1});
        tbl.push_back('{1600,  0,   0, 0, 0, 1, 0, 0, 0,    -1, -1});
        tbl.push_back('{1601,  0,   0, 0, 0, 0, 1, 0, 0,    -1, -1});
        tbl.push_back('{28144, 0,   0, 1, 0, 1, 1, 0, 0,     0, 0});
        tbl.push_back('{28145, 1,   0, 1, 0, 1, 1, 1, 0,     0, 0});
        tbl.push_back('{28146, 2,   0, 1, 0, 1, 1, 1, 1,     0, 0});
        tbl.push_back('{28147, 3,   0, 1, 0, 1, 1, 1, 2,     0, 0});
        tbl.push_back('{28148, 4,   0, 1, 0, 1, 1, 1, 3,     1, 0});
        tbl.push_back('{28149, 5,   0, 1, 0, 1, 1, 1, 4,     1, 1});
        tbl.push_back('{28783, 639, 0, 1, 0, 1, 1, 1, 'h7E,  1, 'h7B});
        tbl.push_back('{28784, 0,   0, 0, 0, 1, 1, 1, 'h7F,  1, 'h7C});
        tbl.push_back('{28785, 0,   0, 0, 0, 1, 1, 0, 0,     1, 'h7D});
        tbl.push_back('{28787, 0,   0, 0, 0, 1, 1, 0, 0,     1, 'h7F});
        tbl.push_back('{28800, 0,   0, 0, 0, 1, 1, 0, 0,     0, 0});
        tbl.push_back('{28950, 6,   1, 1, 0, 1, 1, 1, 5,     1, 2});
        tbl.push_back('{29200, 256, 1, 1, 0, 1, 1, 1, 'hFF,  1, 'hFC});

        repeat (3) @(posedge clk);
        #1;
        chk("rst_x",      x0,  0);
        chk("rst_y",      y0,  0);
        chk("rst_active", act0, 0);
        chk("rst_hs",     hs0, 1);
        chk("rst_vs",     vs0, 1);
        chk("rst_blank_n", bn0, 0);
        chk("rst_rgb",    {r0, g0, b0}, 0);
        chk("rst_sync_n", sn0, 0);
        chk("rst_fs",     fs0, 0);
        chk("rst_hs3",    hs3, 1);

        @(negedge clk);
        rst_a = 1'b0;
        #1;
        kc = 0;
        foreach (tbl[i]) begin
            while (kc < tbl[i].k) begin
                @(posedge clk);
                #1;
                kc++;
            end
            chk($sformatf("k%0d_x", tbl[i].k),   x0,   tbl[i].x);
            chk($sformatf("k%0d_y", tbl[i].k),   y0,   tbl[i].y);
            chk($sformatf("k%0d_act", tbl[i].k), act0, tbl[i].act);
            chk($sformatf("k%0d_fs", tbl[i].k),  fs0,  tbl[i].fs);
            chk($sformatf("k%0d_hs", tbl[i].k),  hs0,  tbl[i].hs);
            chk($sformatf("k%0d_vs", tbl[i].k),  vs0,  tbl[i].vs);
            chk($sformatf("k%0d_bn", tbl[i].k),  bn0,  tbl[i].bn);
            chk($sformatf("k%0d_r", tbl[i].k),   r0,   tbl[i].r);
            chk($sformatf("k%0d_gb", tbl[i].k),  {g0, b0}, tbl[i].bn != 0 ? 16'h8001 : 16'h0000);
            if (tbl[i].bn3 >= 0) begin
                chk($sformatf("k%0d_bn3", tbl[i].k), bn3, tbl[i].bn3);
                chk($sformatf("k%0d_r3", tbl[i].k),  r3,  tbl[i].r3);
            end
        end

        // asynchronous reset in the middle of an active line
        #5;
        rst_a = 1'b1;
        #1;
        chk("mid_rst_x",  x0, 0);
        chk("mid_rst_y",  y0, 0);
        chk("mid_rst_active", act0, 0);
        chk("mid_rst_hs", hs0, 1);
        chk("mid_rst_vs", vs0, 1);
        chk("mid_rst_bn", bn0, 0);
        chk("mid_rst_rgb", {r0, g0, b0}, 0);
        chk("mid_rst_fs", fs0, 0);
        @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        #1;
        chk("post_rst_fs", fs0, 1);
        hs_low = 0;
        vs_low = 0;
        fs_cnt = 0;
        for (int k = 1; k <= 1700; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) chk("post_rst_hs_fall", hs0, 0);
            if (!vs0) vs_low++;
            if (k <= 800 && !hs0) hs_low++;
            if (fs0) fs_cnt++;
        end
        chk("post_rst_vs_low", vs_low, 1600);
        chk("post_rst_hs_low", hs_low, 96);
        chk("post_rst_fs_cnt", fs_cnt, 0);

        // reduced-timing instance: 15 x 9 raster, 135 clocks per frame
        chk("s_rst_hs", hss, 1);
        chk("s_rst_fs", fss, 0);
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        chk("s_k0_fs", fss, 1);
        hs_low  = 0;
        vs_low  = 0;
        bn_high = 0;
        fs_cnt  = 0;
        rgb_bad = 0;
        for (int k = 1; k <= 405; k++) begin
            @(posedge clk);
            #1;
            if (!hss) hs_low++;
            if (!vss) vs_low++;
            if (bns) bn_high++;
            if (fss) fs_cnt++;
            if (bns ? ({rs, gs, bs} !== 24'hFF8001) : ({rs, gs, bs} !== 24'h0)) rgb_bad++;
            if (k == 51) chk("s_k51_act", acts, 0);
            if (k == 65) chk("s_k65_xy_act", {xs, ys, acts}, {11'd0, 11'd0, 1'b1});
            if (k == 117) chk("s_k117_xy_act", {xs, ys, acts}, {11'd7, 11'd3, 1'b1});
            if (k == 118) chk("s_k118_x_act_bn", {xs, acts, bns}, {11'd0, 1'b0, 1'b1});
            if (k == 119) chk("s_k119_bn_r", {bns, rs}, {1'b0, 8'h00});
            if (k == 134) chk("s_k134_fs", fss, 0);
            if (k == 135) chk("s_k135_fs_xy", {fss, xs, ys}, {1'b1, 11'd0, 11'd0});
            if (k == 136) chk("s_k136_fs", fss, 0);
        end
        chk("s_hs_low",  hs_low,  81);
        chk("s_vs_low",  vs_low,  90);
        chk("s_bn_high", bn_high, 96);
        chk("s_fs_cnt",  fs_cnt,  3);
        chk("s_rgb_bad", rgb_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
